// File: rtl/sjtag_target_mod.sv
// Single-wire SJTAG target: decodes a timed frame on the shared line into a
// JTAG cycle (ntrst/tms/tdi/tck) toward the local TAP and returns TDO on the line.
module sjtag_target_mod #(
    parameter int unsigned ACK_TICKS    = 8,
    parameter int unsigned SMP_NTRST    = 11,
    parameter int unsigned SMP_TMS      = 19,
    parameter int unsigned SMP_TDI      = 27,
    parameter int unsigned RET_T        = 44,
    parameter int unsigned TDO_T        = 48,
    parameter int unsigned REL_T        = 59,
    parameter int unsigned TERM_TIMEOUT = 64,
    parameter int unsigned TCK_HIGH     = 8
) (
    input  logic clk_192MHz,
    input  logic rst_n,
    inout  wire  sjtag,
    input  logic tdo_in,
    output logic tck,
    output logic tms,
    output logic tdi,
    output logic ntrst,
    output logic busy,
    output logic frame_err
);

    localparam int unsigned TW    = 7;
    localparam int unsigned T_MAX = (1 << TW) - 1;
    localparam int unsigned MW    = $clog2(TERM_TIMEOUT + 1);
    localparam int unsigned CW    = $clog2(TCK_HIGH + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MARK = 3'd1,
        ACK  = 3'd2,
        DATA = 3'd3,
        RET  = 3'd4,
        TDO  = 3'd5,
        TERM = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   t_q, t_d, t_inc;
    logic [MW-1:0]   term_q, term_d;
    logic [CW-1:0]   tck_cnt_q, tck_cnt_d;
    logic            oe_q, oe_d;
    logic            dout_q, dout_d;
    logic            err_d;
    logic            s1, s2, s2_prev;
    logic            n_s, m_s, d_s;
    logic            tdo_l;

    assign sjtag = oe_q ? dout_q : 1'bz;

    // Line synchronizer; idles high so reset release never looks like a mark.
    always_ff @(posedge clk_192MHz or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= 1'b1;
            s2      <= 1'b1;
            s2_prev <= 1'b1;
        end else begin
            s1      <= sjtag;
            s2      <= s1;
            s2_prev <= s2;
        end
    end

    assign t_inc = (t_q == TW'(T_MAX)) ? t_q : t_q + TW'(1);

    // Next state; line drive is derived from the next state/tick so it lines up with t.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        term_d  = term_q;
        err_d   = 1'b0;
        oe_d    = 1'b0;
        dout_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!s2_prev && s2) state_d = MARK;
            end
            MARK: begin
                if (s2) begin
                    state_d = ACK;
                    t_d     = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            ACK: begin
                t_d = t_inc;
                if (t_q == TW'(ACK_TICKS)) state_d = DATA;
            end
            DATA: begin
                t_d = t_inc;
                if (t_inc == TW'(SMP_TDI + 8) && s2) err_d = 1'b1;
                if (t_q == TW'(RET_T - 1)) state_d = RET;
            end
            RET: begin
                t_d = t_inc;
                if (t_q == TW'(TDO_T - 1)) state_d = TDO;
            end
            TDO: begin
                t_d = t_inc;
                if (t_q == TW'(REL_T)) begin
                    state_d = TERM;
                    term_d  = '0;
                end
            end
            TERM: begin
                // First TERM cycle still sees our own TDO drive through the synchronizer.
                if (term_q != '0 && !s2) begin
                    state_d = IDLE;
                end else if (term_q == MW'(TERM_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    term_d = term_q + MW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        unique case (state_d)
            ACK: begin
                oe_d   = (t_d != TW'(ACK_TICKS));
                dout_d = 1'b0;
            end
            RET: begin
                oe_d   = 1'b1;
                dout_d = 1'b1;
            end
            TDO: begin
                oe_d   = (t_d != TW'(REL_T));
                dout_d = tdo_l;
            end
            default: begin
                oe_d   = 1'b0;
                dout_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_192MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            t_q       <= '0;
            term_q    <= '0;
            oe_q      <= 1'b0;
            dout_q    <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            term_q    <= term_d;
            oe_q      <= oe_d;
            dout_q    <= dout_d;
            busy      <= (state_d != IDLE);
            frame_err <= err_d;
        end
    end

    // Shadow samples; JTAG outputs change together once the TDI sample is in hand.
    always_ff @(posedge clk_192MHz or negedge rst_n) begin
        if (!rst_n) begin
            n_s   <= 1'b0;
            m_s   <= 1'b1;
            d_s   <= 1'b0;
            ntrst <= 1'b0;
            tms   <= 1'b1;
            tdi   <= 1'b0;
            tdo_l <= 1'b0;
        end else if (state_q == DATA) begin
            if (t_inc == TW'(SMP_NTRST)) n_s <= s2;
            if (t_inc == TW'(SMP_TMS))   m_s <= s2;
            if (t_inc == TW'(SMP_TDI))   d_s <= s2;
            if (t_inc == TW'(SMP_TDI + 1)) begin
                ntrst <= n_s;
                tms   <= m_s;
                tdi   <= d_s;
            end
            if (t_q == TW'(RET_T - 1)) tdo_l <= tdo_in;
        end
    end

    // Free-running tck pulse so it finishes even after the FSM has moved on.
    always_comb begin
        tck_cnt_d = (tck_cnt_q != '0) ? tck_cnt_q - CW'(1) : '0;
        if (state_d == TDO && t_d == TW'(REL_T)) tck_cnt_d = CW'(TCK_HIGH);
    end

    always_ff @(posedge clk_192MHz or negedge rst_n) begin
        if (!rst_n) begin
            tck_cnt_q <= '0;
            tck       <= 1'b0;
        end else begin
            tck_cnt_q <= tck_cnt_d;
            tck       <= (tck_cnt_d != '0);
        end
    end

endmodule

// File: doc/sjtag_target_mod.md
SJTAG_TARGET_MOD -- requirements
Module: sjtag_target_mod

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ACK_TICKS, 8: ticks the target drives the line low to end the timing mark.
- SMP_NTRST, 11: tick t at which nTRST is sampled.
- SMP_TMS, 19: tick t at which TMS is sampled.
- SMP_TDI, 27: tick t at which TDI is sampled.
- RET_T, 44: tick t at which the return-clock high drive starts.
- TDO_T, 48: tick t at which the TDO drive starts.
- REL_T, 59: tick t at which the line is released after TDO.
- TERM_TIMEOUT, 64: maximum ticks to wait for the initiator's terminating low.
- TCK_HIGH, 8: tck high width in ticks.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk_192MHz, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- sjtag, inout, 1: single-wire SJTAG line.
- tdo_in, in, 1: TDO from the local JTAG TAP.
- tck, out, 1: JTAG clock to the TAP.
- tms, out, 1: JTAG TMS to the TAP.
- tdi, out, 1: JTAG TDI to the TAP.
- ntrst, out, 1: JTAG TRST_N to the TAP.
- busy, out, 1: high whenever the FSM is not in IDLE.
- frame_err, out, 1: one-cycle pulse on a protocol error.

Function
REQ-003 The sjtag line SHALL be driven only through an internal output enable; when the enable is low, sjtag SHALL be high-Z.

REQ-004 The sjtag input SHALL pass through a 2-flop synchronizer. "Line" in the requirements below means the synchronized value s2.

REQ-005 FSM states SHALL be: IDLE, MARK, ACK, DATA, RET, TDO, TERM.

REQ-006 IDLE:
- Line released.
- A rising edge (previous s2=0, current s2=1) SHALL move the FSM to MARK.

REQ-007 MARK:
- Line high for 2 consecutive cycles: go to ACK with t=0.
- Line low before that: return to IDLE with no error.

REQ-008 A 7-bit counter t SHALL start at 0 on entry to ACK and increment every cycle through ACK, DATA, RET and TDO.

REQ-009 ACK: drive sjtag=0 for t=0..ACK_TICKS-1, release at t=ACK_TICKS, then enter DATA.

REQ-010 DATA:
- Line SHALL stay released.
- At t=SMP_NTRST, SMP_TMS and SMP_TDI, capture s2 into shadow bits n_s, m_s and d_s respectively.

REQ-011 At t=SMP_TDI+1, ntrst/tms/tdi SHALL be updated simultaneously from n_s/m_s/d_s.

REQ-012 At t=RET_T-1, tdo_in SHALL be latched into tdo_l.

REQ-013 RET: drive sjtag=1 for t=RET_T..TDO_T-1.

REQ-014 TDO: drive sjtag=tdo_l for t=TDO_T..REL_T-1, release at t=REL_T, then enter TERM.

REQ-015 tck pulse:
- tck SHALL go high at t=REL_T and stay high exactly TCK_HIGH cycles.
- The pulse is driven by an independent counter, so it completes even if the FSM leaves TERM.

REQ-016 TERM:
- Line low: go to IDLE.
- Line still high after TERM_TIMEOUT cycles: pulse frame_err and go to IDLE.

REQ-017 If the line reads high at any DATA sample point where the initiator must drive low (t=SMP_TDI+8), frame_err SHALL pulse; the frame SHALL still complete.

REQ-018 A rising edge detected during DATA, RET, TDO or TERM SHALL NOT restart the frame.

REQ-019 Back-to-back frames: IDLE SHALL accept a new mark on the cycle after leaving TERM, even while tck is still high.

REQ-020 t SHALL saturate and never wrap within a frame; all compares SHALL be exact-equality on t.

Reset
REQ-021 Assertion of rst_n SHALL immediately and asynchronously set:
- FSM=IDLE;
- sjtag output enable=0, i.e. line released mid-frame;
- t=0 and the tck counter=0;
- tck=0, tms=1, tdi=0, ntrst=0;
- busy=0, frame_err=0;
- synchronizer flops=1.

REQ-022 After reset release, ntrst SHALL stay 0 until the first completed DATA phase.

Verification
REQ-023 Nominal frame:
- Stimulus: bus model drives high for 4 ticks then releases with pull-up; drives nTRST=1, TMS=0, TDI=1 in 8-tick slots starting t=7; tdo_in=1.
- Response: ack low at t=0..7; ntrst=1, tms=0, tdi=1 at t=28; sjtag=1 at t=44..58; tck high at t=59..66 (t=REL_T); busy low after TERM.

REQ-024 TDO=0:
- Stimulus: same frame with tdo_in=0.
- Response: sjtag=1 at t=44..47, 0 at t=48..58.

REQ-025 Glitch mark:
- Stimulus: line high for 1 cycle, then low.
- Response: FSM returns to IDLE; no ack drive; frame_err=0.

REQ-026 Terminate timeout:
- Stimulus: nominal frame but line held high after release.
- Response: frame_err pulses once 64 cycles into TERM; FSM=IDLE.

REQ-027 Reset mid-frame:
- Stimulus: assert rst_n at t=50.
- Response: sjtag high-Z in the same cycle; all outputs at their reset values.

REQ-028 Back-to-back:
- Stimulus: two frames with TMS=1 then TMS=0, the second mark starting 1 cycle after the first TERM exits.
- Response: two tck pulses; tms=1 then tms=0.
